hazard_ctrl_mp: RTL and testbench

//  Next-gen pipeline hazard controller for the 5-stage ARM core. Handles NRD read ports per instruction
//  (M>W forwarding, load-use stall) and variable-latency data memory (whole-pipe freeze, timeout flag).

---
 rtl/hazard_ctrl_mp.sv | 174 +++++++++++++++++
 tb/tb_hazard_ctrl_mp.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_mp.sv
// Hazard controller for the 5-stage core: forwarding, load-use stall, memory-wait freeze and redirect flush.
// Define HAZ_PERF_CNT_EN to build the saturating perf counters; otherwise they are tied to zero.
module hazard_ctrl_mp #(
  parameter int REG_AW    = 4,
  parameter int NRD       = 3,
  parameter int FLUSH_CYC = 1,
  parameter int MEM_TO    = 64,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NRD*REG_AW-1:0]   ra_d,
  input  logic [NRD-1:0]          ra_d_valid,
  input  logic [NRD*REG_AW-1:0]   ra_e,
  input  logic [NRD-1:0]          ra_e_valid,
  input  logic [REG_AW-1:0]       wa_e,
  input  logic                    wa_e_valid,
  input  logic [REG_AW-1:0]       wa_m,
  input  logic                    wa_m_valid,
  input  logic [REG_AW-1:0]       wa_w,
  input  logic                    wa_w_valid,
  input  logic                    regwrite_e,
  input  logic                    regwrite_m,
  input  logic                    regwrite_w,
  input  logic                    memtoreg_e,
  input  logic                    memtoreg_m,
  input  logic                    mem_ready,
  input  logic                    br_taken_e,
  input  logic                    br_pred_e,
  input  logic                    pcwr_taken_e,
  output logic [2*NRD-1:0]        forward_e,
  output logic                    stall_f,
  output logic                    stall_d,
  output logic                    stall_e,
  output logic                    stall_m,
  output logic                    flush_d,
  output logic                    flush_e,
  output logic                    flush_w,
  output logic                    mem_err,
  output logic [CNT_W-1:0]        cnt_ldstall,
  output logic [CNT_W-1:0]        cnt_memwait,
  output logic [CNT_W-1:0]        cnt_flush
);

  localparam int WAIT_W = $clog2(MEM_TO + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TO);
  localparam logic [3:0] FCNT_RELOAD = 4'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, REDIR} state_t;

  state_t             state, state_nx;
  logic [3:0]         fcnt, fcnt_nx;
  logic [WAIT_W-1:0]  wait_cnt, wait_nx;
  logic [2*NRD-1:0]   fwd;
  logic [NRD-1:0]     ld_match;
  logic               ldhit, memwait, redirect;
  logic               ld_stall, redir_evt, flush_d_c;

  always_comb begin
    fwd      = '0;
    ld_match = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ra_e_valid[i] && wa_m_valid && regwrite_m && (ra_e[i*REG_AW +: REG_AW] == wa_m))
        fwd[2*i +: 2] = 2'b10;
      else if (ra_e_valid[i] && wa_w_valid && regwrite_w && (ra_e[i*REG_AW +: REG_AW] == wa_w))
        fwd[2*i +: 2] = 2'b01;
      ld_match[i] = ra_d_valid[i] && (ra_d[i*REG_AW +: REG_AW] == wa_e);
    end
  end

  assign ldhit    = memtoreg_e & regwrite_e & wa_e_valid & (|ld_match);
  assign memwait  = memtoreg_m & ~mem_ready;
  assign redirect = (br_taken_e ^ br_pred_e) | pcwr_taken_e;

  // A pending memory access freezes everything; the cycle mem_ready arrives behaves as RUN.
  always_comb begin
    state_nx  = state;
    fcnt_nx   = fcnt;
    ld_stall  = 1'b0;
    redir_evt = 1'b0;
    flush_d_c = 1'b0;
    if (memwait) begin
      state_nx = MEMWAIT;
      fcnt_nx  = '0;
    end else begin
      case (state)
        RUN, MEMWAIT: begin
          state_nx = RUN;
          if (redirect) begin
            redir_evt = 1'b1;
            flush_d_c = 1'b1;
            if (FLUSH_CYC > 1) begin
              fcnt_nx  = FCNT_RELOAD;
              state_nx = REDIR;
            end
          end else if (ldhit) begin
            ld_stall = 1'b1;
          end
        end
        REDIR: begin
          flush_d_c = 1'b1;
          if (redirect) begin
            redir_evt = 1'b1;
            fcnt_nx   = FCNT_RELOAD;
          end else if (fcnt <= 4'd1) begin
            fcnt_nx  = '0;
            state_nx = RUN;
          end else begin
            fcnt_nx = fcnt - 4'd1;
          end
        end
        default: begin
          state_nx = RUN;
          fcnt_nx  = '0;
        end
      endcase
    end
  end

  always_comb begin
    wait_nx = '0;
    if (memwait)
      wait_nx = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      fcnt     <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      fcnt     <= fcnt_nx;
      wait_cnt <= wait_nx;
      if (memwait && (wait_nx == WAIT_MAX))
        mem_err <= 1'b1;
    end
  end

  // Everything combinational is held quiet while reset is asserted.
  assign forward_e = reset_n ? fwd : '0;
  assign stall_f   = reset_n & (memwait | ld_stall);
  assign stall_d   = reset_n & (memwait | ld_stall);
  assign stall_e   = reset_n & memwait;
  assign stall_m   = reset_n & memwait;
  assign flush_d   = reset_n & flush_d_c;
  assign flush_e   = reset_n & (ld_stall | redir_evt);
  assign flush_w   = reset_n & memwait;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_ldstall <= '0;
      cnt_memwait <= '0;
      cnt_flush   <= '0;
    end else begin
      if (ld_stall && (cnt_ldstall != CNT_MAX))
        cnt_ldstall <= cnt_ldstall + 1'b1;
      if (memwait && (cnt_memwait != CNT_MAX))
        cnt_memwait <= cnt_memwait + 1'b1;
      if (redir_evt && (cnt_flush != CNT_MAX))
        cnt_flush <= cnt_flush + 1'b1;
    end
  end
`else
  assign cnt_ldstall = '0;
  assign cnt_memwait = '0;
  assign cnt_flush   = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mp.sv
// Directed bench for hazard_ctrl_mp (FLUSH_CYC=3, MEM_TO=8); perf counter checks follow HAZ_PERF_CNT_EN.
module tb_hazard_ctrl_mp;

`ifdef HAZ_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] ra_d, ra_e;
  logic [2:0]  ra_d_valid, ra_e_valid;
  logic [3:0]  wa_e, wa_m, wa_w;
  logic        wa_e_valid, wa_m_valid, wa_w_valid;
  logic        regwrite_e, regwrite_m, regwrite_w;
  logic        memtoreg_e, memtoreg_m, mem_ready;
  logic        br_taken_e, br_pred_e, pcwr_taken_e;
  logic [5:0]  forward_e;
  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, mem_err;
  logic [15:0] cnt_ldstall, cnt_memwait, cnt_flush;
  logic [6:0]  ctl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

  hazard_ctrl_mp #(.REG_AW(4), .NRD(3), .FLUSH_CYC(3), .MEM_TO(8), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ra_d(ra_d), .ra_d_valid(ra_d_valid), .ra_e(ra_e), .ra_e_valid(ra_e_valid),
    .wa_e(wa_e), .wa_e_valid(wa_e_valid), .wa_m(wa_m), .wa_m_valid(wa_m_valid),
    .wa_w(wa_w), .wa_w_valid(wa_w_valid),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m), .mem_ready(mem_ready),
    .br_taken_e(br_taken_e), .br_pred_e(br_pred_e), .pcwr_taken_e(pcwr_taken_e),
    .forward_e(forward_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w), .mem_err(mem_err),
    .cnt_ldstall(cnt_ldstall), .cnt_memwait(cnt_memwait), .cnt_flush(cnt_flush)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ra_d = '0; ra_e = '0; ra_d_valid = '0; ra_e_valid = '0;
    wa_e = '0; wa_m = '0; wa_w = '0;
    wa_e_valid = 0; wa_m_valid = 0; wa_w_valid = 0;
    regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    memtoreg_e = 0; memtoreg_m = 0; mem_ready = 1;
    br_taken_e = 0; br_pred_e = 0; pcwr_taken_e = 0;
  endtask

  // load in E writing r3, D reads r3 on port 2
  task automatic set_ldhit(input logic v);
    memtoreg_e = 1; regwrite_e = 1; wa_e = 4'd3; wa_e_valid = 1;
    ra_d = {4'd3, 4'd0, 4'd0}; ra_d_valid = {v, 2'b11};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with hazards present on the inputs
    clr();
    reset_n = 0;
    ra_e = 12'h050; ra_e_valid = 3'b010; wa_m = 4'd5; wa_m_valid = 1; regwrite_m = 1;
    memtoreg_m = 1; mem_ready = 0;
    tick(); tick();
    chk("rst_fwd", forward_e, 6'b0);
    chk("rst_ctl", ctl, 7'b0);
    chk("rst_err", mem_err, 0);
    clr();
    reset_n = 1;
    tick();
    chk("rst_cnt", {cnt_ldstall, cnt_memwait}, 32'h0);

    // forwarding: M beats W on same address, then W alone
    ra_e = 12'h050; ra_e_valid = 3'b010;
    wa_m = 4'd5; wa_m_valid = 1; regwrite_m = 1;
    wa_w = 4'd5; wa_w_valid = 1; regwrite_w = 1;
    #1 chk("fwd_m_wins", forward_e, 6'b001000);
    regwrite_m = 0;
    #1 chk("fwd_w_only", forward_e, 6'b000100);
    ra_e = {4'd7, 4'd5, 4'd2}; ra_e_valid = 3'b111;
    wa_m = 4'd7; regwrite_m = 1; wa_w = 4'd2;
    #1 chk("fwd_mixed", forward_e, 6'b100001);
    wa_m_valid = 0;
    #1 chk("fwd_m_invalid", forward_e, 6'b000001);
    chk("fwd_no_ctl", ctl, 7'b0);
    clr();

    // load-use: one bubble, then no stall when the port is invalid
    tick();
    set_ldhit(1'b1);
    #1 chk("ld_stall", ctl, 7'b1100010);
    tick();
    clr();
    #1 chk("ld_one_cycle", ctl, 7'b0);
    set_ldhit(1'b0);
    #1 chk("ld_port_invalid", ctl, 7'b0);
    clr();
    br_taken_e = 1; br_pred_e = 1;
    #1 chk("pred_correct", ctl, 7'b0);
    clr();
    tick();
    chk("cnt_ldstall", cnt_ldstall, PERF ? 1 : 0);

    // memory wait for four cycles, redirect ignored meanwhile
    memtoreg_m = 1; mem_ready = 0; br_taken_e = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("memwait_ctl", ctl, 7'b1111001);
      tick();
    end
    br_taken_e = 0; mem_ready = 1;
    #1 chk("memwait_release", ctl, 7'b0);
    tick();
    memtoreg_m = 0;
    chk("cnt_memwait", cnt_memwait, PERF ? 4 : 0);
    chk("memwait_no_err", mem_err, 0);
    chk("memwait_no_flush_cnt", cnt_flush, 0);

    // timeout after eight wait cycles, sticky past release
    memtoreg_m = 1; mem_ready = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (i == 7) chk("to_not_yet", mem_err, 0);
      tick();
    end
    chk("to_set", mem_err, 1);
    mem_ready = 1;
    tick();
    memtoreg_m = 0;
    tick();
    chk("to_sticky", mem_err, 1);
    chk("to_ctl_idle", ctl, 7'b0);

    // mispredict with three flush cycles; load-use in cycle 2 ignored
    br_taken_e = 1; br_pred_e = 0;
    #1 chk("redir_c1", ctl, 7'b0000110);
    tick();
    clr();
    set_ldhit(1'b1);
    #1 chk("redir_c2_ldhit_ignored", ctl, 7'b0000100);
    tick();
    clr();
    #1 chk("redir_c3", ctl, 7'b0000100);
    tick();
    #1 chk("redir_done", ctl, 7'b0);
    chk("cnt_flush", cnt_flush, PERF ? 1 : 0);
    chk("cnt_ldstall_unchanged", cnt_ldstall, PERF ? 1 : 0);

    // reset asserted in the middle of a redirect
    pcwr_taken_e = 1;
    #1 chk("pcwr_redir", ctl, 7'b0000110);
    tick();
    pcwr_taken_e = 0;
    ra_e = 12'h050; ra_e_valid = 3'b010; wa_m = 4'd5; wa_m_valid = 1; regwrite_m = 1;
    #1 chk("mid_redir", ctl, 7'b0000100);
    reset_n = 0;
    #1 chk("rst_mid_ctl", ctl, 7'b0);
    chk("rst_mid_fwd", forward_e, 6'b0);
    tick();
    clr();
    reset_n = 1;
    #1 chk("rel_ctl", ctl, 7'b0);
    tick();
    #1 chk("rel_no_flush", ctl, 7'b0);
    chk("rel_err_clr", mem_err, 0);
    chk("rel_cnt_clr", {cnt_flush, cnt_memwait}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
